// File: rtl/req_capture_encoder8_pkg.sv
// Shared widths and FSM encoding for the request capture front end of the 8x3 encoder.
package req_capture_encoder8_pkg;

    localparam int unsigned NREQ   = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/req_capture_encoder8_if.sv
// Valid/ready code channel from the request capture front end to its consumer.
interface req_capture_encoder8_if;
    import req_capture_encoder8_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;

    modport master (output out_valid, output out_code, input out_ready);
    modport slave  (input out_valid, input out_code, output out_ready);

endinterface

// File: rtl/encoder_8x3.sv
// Combinational 8x3 encoder; expects a one-hot input word.
module encoder_8x3
    import req_capture_encoder8_pkg::*;
(
    input  logic [NREQ-1:0]   onehot,
    output logic [CODE_W-1:0] code
);

    always_comb begin
        code = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (onehot[i]) code = code | CODE_W'(i);
        end
    end

endmodule

// File: rtl/req_capture_encoder8.sv
// Captures request events into a pending register, grants one bit at a time and emits its code.
// Define RR_PRIORITY_EN for round-robin selection; otherwise the highest pending index wins.
module req_capture_encoder8
    import req_capture_encoder8_pkg::*;
#(
    parameter bit EDGE_DETECT = 1'b1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_i,
    req_capture_encoder8_if.master  bus,
    output logic [NREQ-1:0]         pending_o,
    output logic                    overrun_o
);

    state_t              state_q, state_d;
    logic [NREQ-1:0]     req_q;
    logic [NREQ-1:0]     pending_q;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                overrun_q;
    logic [NREQ-1:0]     ev;
    logic [NREQ-1:0]     clr;
    logic [NREQ-1:0]     sel;
    logic [CODE_W-1:0]   sel_code;
    logic                accept;

    assign ev     = EDGE_DETECT ? (req_i & ~req_q) : req_i;
    assign accept = (state_q == HOLD) && bus.out_ready;
    assign clr    = accept ? grant_q : '0;

`ifdef RR_PRIORITY_EN
    logic [CODE_W-1:0] ptr_q;
    logic [CODE_W-1:0] idx;
    logic              found;

    // Search from ptr+1 upward, wrapping through 7->0; the pointer itself is checked last.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = ptr_q + CODE_W'(off);
            if (!found && pending_q[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr_q <= CODE_W'(NREQ - 1);
        else if (accept) ptr_q <= code_q;
    end
`else
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pending_q[i]) sel = NREQ'(1) << i;
        end
    end
`endif

    encoder_8x3 u_enc (
        .onehot (sel),
        .code   (sel_code)
    );

    // Grant is latched in IDLE from the registered pending word and held through HOLD.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_d = sel;
                    code_d  = sel_code;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = IDLE;
            end
        endcase
    end

    // A new event on a bit being cleared this cycle re-pends it and is not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            code_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_i;
            pending_q <= (pending_q & ~clr) | ev;
            grant_q   <= grant_d;
            code_q    <= code_d;
            overrun_q <= overrun_q | (|(ev & pending_q & ~clr));
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_code  = code_q;
    assign pending_o     = pending_q;
    assign overrun_o     = overrun_q;

endmodule
